// File: rtl/cvi_to_avst_video.sv
// Clocked-video receiver: turns datavalid/h_sync/v_sync framed pixels into
// Avalon-ST video packets (header beat + H_ACTIVE*V_ACTIVE pixels, eop on last).
module cvi_to_avst_video #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] vid_data,
    input  logic        vid_datavalid,
    input  logic        vid_h_sync,
    input  logic        vid_v_sync,
    output logic [23:0] source_data,
    output logic        source_valid,
    input  logic        source_ready,
    output logic        source_startofpacket,
    output logic        source_endofpacket,
    input  logic        status_clear,
    output logic        overflow,
    output logic        frame_error,
    output logic [15:0] frame_count,
    output logic [2:0]  debug_state
);

    // Handshake: a beat transfers in any cycle where source_valid and
    // source_ready are both high (readyLatency 0); data is show-ahead.

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int XW  = $clog2(H_ACTIVE + 1);
    localparam int YW  = $clog2(V_ACTIVE + 1);
    localparam int LXW = $clog2(H_ACTIVE + 2) + 1;

    localparam logic [XW-1:0]  X_LAST    = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0]  Y_LAST    = YW'(V_ACTIVE - 1);
    localparam logic [LXW-1:0] LX_FULL   = LXW'(H_ACTIVE);
    localparam logic [AW:0]    FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_HEADER = 3'd1;
    localparam logic [2:0] ST_PIXELS = 3'd2;
    localparam logic [2:0] ST_DONE   = 3'd3;
    localparam logic [2:0] ST_DROP   = 3'd4;
    localparam logic [2:0] ST_FLUSH  = 3'd5;

    logic [2:0]     state, state_next;
    logic           vs_q, hs_q;
    logic           vs_rise, hs_rise;
    logic [XW-1:0]  x;
    logic [YW-1:0]  y;
    logic [LXW-1:0] lx;
    logic           last_pixel;
    logic           line_err;

    logic           wr_req;
    logic [25:0]    wr_word;
    logic           set_ferr, set_ovf;
    logic           xy_clear, xy_adv;

    logic [25:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;
    logic           full, empty, push, pop;
    logic [25:0]    head;

    assign vs_rise    = vid_v_sync & ~vs_q;
    assign hs_rise    = vid_h_sync & ~hs_q;
    assign last_pixel = (x == X_LAST) && (y == Y_LAST);
    assign line_err   = hs_rise && (lx != '0) && (lx != LX_FULL);

    assign full  = (count == FIFO_FULL);
    assign empty = (count == '0);
    // A write into a full FIFO is lost even if a pop frees a slot this cycle.
    assign push  = wr_req & ~full;
    assign pop   = source_valid & source_ready;
    assign head  = mem[rd_ptr];

    assign source_valid         = ~empty;
    assign source_data          = empty ? 24'h000000 : head[23:0];
    assign source_startofpacket = ~empty & head[25];
    assign source_endofpacket   = ~empty & head[24];
    assign debug_state          = state;

    always_comb begin
        state_next = state;
        wr_req     = 1'b0;
        wr_word    = '0;
        set_ferr   = 1'b0;
        set_ovf    = 1'b0;
        xy_clear   = 1'b0;
        xy_adv     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (vs_rise) state_next = ST_HEADER;
            end
            ST_HEADER: begin
                if (vid_datavalid) set_ferr = 1'b1;
                if (!full) begin
                    wr_req     = 1'b1;
                    wr_word    = {1'b1, 1'b0, 24'h000000};
                    xy_clear   = 1'b1;
                    state_next = ST_PIXELS;
                end
            end
            ST_PIXELS: begin
                // A v_sync rise takes priority over a coincident pixel.
                if (vs_rise) begin
                    set_ferr   = 1'b1;
                    state_next = ST_FLUSH;
                end else if (vid_datavalid) begin
                    if (full) begin
                        set_ovf    = 1'b1;
                        state_next = ST_DROP;
                    end else begin
                        wr_req  = 1'b1;
                        wr_word = {1'b0, last_pixel, vid_data};
                        xy_adv  = 1'b1;
                        if (last_pixel) state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (vid_datavalid) set_ferr = 1'b1;
                if (vs_rise) state_next = ST_HEADER;
            end
            ST_DROP: begin
                if (vs_rise) state_next = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (vid_datavalid) set_ferr = 1'b1;
                if (!full) begin
                    wr_req     = 1'b1;
                    wr_word    = {1'b0, 1'b1, 24'h000000};
                    state_next = ST_HEADER;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            vs_q  <= 1'b0;
            hs_q  <= 1'b0;
            x     <= '0;
            y     <= '0;
            lx    <= '0;
        end else begin
            state <= state_next;
            vs_q  <= vid_v_sync;
            hs_q  <= vid_h_sync;
            if (xy_clear) begin
                x <= '0;
                y <= '0;
            end else if (xy_adv) begin
                if (x == X_LAST) begin
                    x <= '0;
                    y <= (y == Y_LAST) ? '0 : y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end
            // Saturating count so runaway lines never wrap back to a legal length.
            if (hs_rise) lx <= vid_datavalid ? LXW'(1) : '0;
            else if (vid_datavalid && lx != '1) lx <= lx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow    <= 1'b0;
            frame_error <= 1'b0;
            frame_count <= '0;
        end else begin
            if (set_ovf) overflow <= 1'b1;
            else if (status_clear) overflow <= 1'b0;
            if (set_ferr || line_err) frame_error <= 1'b1;
            else if (status_clear) frame_error <= 1'b0;
            if (push && wr_word[24]) frame_count <= status_clear ? 16'd1 : frame_count + 16'd1;
            else if (status_clear) frame_count <= '0;
        end
    end

endmodule

// File: tb/tb_cvi_to_avst_video.sv
// Directed bench for cvi_to_avst_video with a frame-level expected-beat model.
module tb_cvi_to_avst_video;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int D  = 4;
  localparam int HV = H * V;

  localparam int M_IDLE    = 0;
  localparam int M_OPEN    = 1;
  localparam int M_DONE    = 2;
  localparam int M_DROPPED = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] vid_data = '0;
  logic        vid_datavalid = 1'b0;
  logic        vid_h_sync = 1'b0;
  logic        vid_v_sync = 1'b0;
  logic [23:0] source_data;
  logic        source_valid;
  logic        source_ready = 1'b1;
  logic        source_startofpacket;
  logic        source_endofpacket;
  logic        status_clear = 1'b0;
  logic        overflow;
  logic        frame_error;
  logic [15:0] frame_count;
  logic [2:0]  debug_state;

  cvi_to_avst_video #(.H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .vid_data(vid_data), .vid_datavalid(vid_datavalid),
    .vid_h_sync(vid_h_sync), .vid_v_sync(vid_v_sync),
    .source_data(source_data), .source_valid(source_valid), .source_ready(source_ready),
    .source_startofpacket(source_startofpacket), .source_endofpacket(source_endofpacket),
    .status_clear(status_clear), .overflow(overflow), .frame_error(frame_error),
    .frame_count(frame_count), .debug_state(debug_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: expected beats {sop, eop, data} in order, plus flags.
  logic [25:0] exp_q[$];
  logic [25:0] got_beat;
  int          m_state;
  int          m_pix;
  int          m_last_len;
  logic [15:0] m_cnt;
  logic        m_ovf;
  logic        m_ferr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  task automatic push_beat(input logic s, input logic e, input logic [23:0] d);
    exp_q.push_back({s, e, d});
    if (e) m_cnt++;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_state = M_IDLE; m_pix = 0; m_last_len = 0;
    m_cnt = '0; m_ovf = 1'b0; m_ferr = 1'b0;
  endtask

  task automatic model_clear();
    m_cnt = '0; m_ovf = 1'b0; m_ferr = 1'b0;
  endtask

  task automatic model_vsync();
    if (m_state == M_OPEN) begin
      m_ferr = 1'b1;
      push_beat(1'b0, 1'b1, 24'h0);
    end else if (m_state == M_DROPPED) begin
      push_beat(1'b0, 1'b1, 24'h0);
    end
    push_beat(1'b1, 1'b0, 24'h0);
    m_state = M_OPEN;
    m_pix = 0;
  endtask

  task automatic model_hsync();
    if (m_last_len != 0 && m_last_len != H) m_ferr = 1'b1;
    m_last_len = 0;
  endtask

  task automatic model_pixel(input logic [23:0] d);
    m_last_len++;
    if (m_state == M_OPEN) begin
      if (!source_ready && exp_q.size() >= D) begin
        m_ovf = 1'b1;
        m_state = M_DROPPED;
      end else begin
        push_beat(1'b0, (m_pix == HV - 1), d);
        m_pix++;
        if (m_pix == HV) m_state = M_DONE;
      end
    end else if (m_state == M_DONE) begin
      m_ferr = 1'b1;
    end
  endtask

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (!reset && source_valid && source_ready) begin
      got_beat = {source_startofpacket, source_endofpacket, source_data};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat actual=%0h expected=none", got_beat);
      end else begin
        check("beat", got_beat, exp_q.pop_front());
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; vid_datavalid = 1'b0; vid_h_sync = 1'b0; vid_v_sync = 1'b0;
    status_clear = 1'b0; source_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic vsync_pulse(input bit lat);
    @(posedge clk); #1;
    vid_v_sync = 1'b1; vid_datavalid = 1'b0;
    model_vsync();
    if (lat) begin @(negedge clk); check("lat_n0_valid", source_valid, 0); end
    @(posedge clk); #1;
    vid_v_sync = 1'b0;
    if (lat) begin @(negedge clk); check("lat_n1_valid", source_valid, 0); end
    @(posedge clk); #1;
    if (lat) begin
      @(negedge clk);
      check("lat_n2_valid", source_valid, 1);
      check("lat_n2_sop", source_startofpacket, 1);
    end
  endtask

  task automatic send_line(input int n, input int base, input bit lat);
    @(posedge clk); #1;
    vid_h_sync = 1'b1; vid_datavalid = 1'b0;
    model_hsync();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      vid_h_sync = 1'b0; vid_datavalid = 1'b1; vid_data = 24'(base + i);
      model_pixel(vid_data);
      if (lat && i == 1) begin
        @(negedge clk);
        check("pix_lat_valid", source_valid, 1);
        check("pix_lat_data", source_data, 24'(base));
      end
    end
    @(posedge clk); #1;
    vid_h_sync = 1'b0; vid_datavalid = 1'b0;
  endtask

  task automatic send_frame(input int n, input int base, input bit lat);
    int rem;
    int k;
    bit first;
    vsync_pulse(lat);
    rem = n;
    first = 1'b1;
    while (rem > 0) begin
      k = (rem > H) ? H : rem;
      send_line(k, base + n - rem, lat && first);
      first = 1'b0;
      rem -= k;
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d expected=0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_overflow"}, overflow, m_ovf);
    check({tag, "_frame_error"}, frame_error, m_ferr);
    check({tag, "_frame_count"}, frame_count, m_cnt);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    model_reset();
    do_reset();
    @(negedge clk);
    check("rst_valid", source_valid, 0);
    check("rst_sop", source_startofpacket, 0);
    check("rst_eop", source_endofpacket, 0);
    check("rst_data", source_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_error", frame_error, 0);
    check("rst_frame_count", frame_count, 0);

    // Two good frames, pixels 1..8 each.
    send_frame(HV, 1, 1'b1);
    send_frame(HV, 1, 1'b0);
    wait_drain();
    check_model("good");
    check("good_count_lit", frame_count, 16'd2);
    check("good_ferr_lit", frame_error, 0);

    // Short frame: 5 pixels, then v_sync closes it with a filler eop.
    do_reset();
    send_frame(5, 1, 1'b0);
    vsync_pulse(1'b0);
    wait_drain();
    check_model("short");
    check("short_ferr_lit", frame_error, 1);
    check("short_count_lit", frame_count, 16'd1);

    // Long frame: pixels 9 and 10 dropped after the eop beat.
    do_reset();
    send_frame(10, 1, 1'b0);
    wait_drain();
    check_model("long");
    check("long_ferr_lit", frame_error, 1);
    check("long_count_lit", frame_count, 16'd1);

    // Backpressure: sink stalled for a whole frame.
    do_reset();
    @(posedge clk); #1 source_ready = 1'b0;
    send_frame(HV, 1, 1'b0);
    @(negedge clk);
    check("bp_overflow_lit", overflow, 1);
    check("bp_valid_lit", source_valid, 1);
    check("bp_queued", exp_q.size(), D);
    @(posedge clk); #1 source_ready = 1'b1;
    wait_drain();
    send_frame(HV, 1, 1'b0);
    wait_drain();
    check_model("bp");
    check("bp_count_lit", frame_count, 16'd2);
    check("bp_ferr_lit", frame_error, 0);

    // Line check, set-beats-clear, then plain clear.
    do_reset();
    vsync_pulse(1'b0);
    send_line(3, 1, 1'b0);
    send_line(4, 4, 1'b0);
    send_line(1, 8, 1'b0);
    wait_drain();
    check_model("line");
    check("line_ferr_lit", frame_error, 1);
    @(posedge clk); #1;
    status_clear = 1'b1; vid_datavalid = 1'b1; vid_data = 24'h00000a;
    model_clear();
    model_pixel(vid_data);
    @(posedge clk); #1;
    status_clear = 1'b0; vid_datavalid = 1'b0;
    @(negedge clk);
    check_model("clr_set");
    check("clr_set_ferr_lit", frame_error, 1);
    @(posedge clk); #1 status_clear = 1'b1;
    model_clear();
    @(posedge clk); #1 status_clear = 1'b0;
    @(negedge clk);
    check_model("clr");
    check("clr_ferr_lit", frame_error, 0);
    check("clr_count_lit", frame_count, 0);

    // Reset mid-frame with header + 2 pixels queued.
    do_reset();
    @(posedge clk); #1 source_ready = 1'b0;
    vsync_pulse(1'b0);
    send_line(2, 1, 1'b0);
    @(negedge clk);
    check("mid_queued_valid", source_valid, 1);
    check("mid_queued", exp_q.size(), 3);
    @(posedge clk); #1 reset = 1'b1;
    model_reset();
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", source_valid, 0);
    source_ready = 1'b1;
    send_line(H, 1, 1'b0);
    send_line(H, 5, 1'b0);
    @(negedge clk);
    check("mid_silent_valid", source_valid, 0);
    send_frame(HV, 1, 1'b0);
    wait_drain();
    check_model("mid");
    check("mid_count_lit", frame_count, 16'd1);

    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
